// File: rtl/bus_memory_responder_if.sv
// Cache-bus bundle between an L1 line initiator (master) and the memory responder (slave).
interface bus_memory_responder_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned TW = 13
) ();
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

// File: rtl/bus_memory_responder.sv
// Main-memory end of the cache bus: serves 64-byte line reads and accepts line write-backs
// from a word-addressed array, one request at a time.
module bus_memory_responder #(
  parameter int unsigned              BUS_DATA_WIDTH = 64,
  parameter int unsigned              BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_TAG_WIDTH-1:0] TAG_READ       = BUS_TAG_WIDTH'(1),
  parameter logic [BUS_TAG_WIDTH-1:0] TAG_WRITE      = BUS_TAG_WIDTH'(4),
  parameter int unsigned              BEATS          = 8,
  parameter int unsigned              MEM_WORDS      = 4096,
  parameter int unsigned              READ_LATENCY   = 4,
  parameter int unsigned              WDATA_DELAY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_memory_responder_if.slave bus,
  output logic                  busy,
  output logic [7:0]            bad_tag_cnt
);
  localparam int unsigned DW   = BUS_DATA_WIDTH;
  localparam int unsigned TW   = BUS_TAG_WIDTH;
  localparam int unsigned AW   = $clog2(MEM_WORDS);
  localparam int unsigned BW   = $clog2(BEATS);
  localparam int unsigned LW   = BW + 3;
  localparam int unsigned WMAX = (READ_LATENCY > WDATA_DELAY) ? READ_LATENCY : WDATA_DELAY;
  localparam int unsigned WW   = $clog2(WMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_WDATA, S_WRESP, S_RWAIT, S_RBEAT, S_RGAP
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [DW-1:LW] r_line;
  logic [TW-1:0]  r_tag;
  logic [BW-1:0]  r_beat, w_beat_nxt;
  logic [WW-1:0]  r_wait, w_wait_nxt;
  logic           r_reqack, r_respcyc, r_busy;
  logic [DW-1:0]  r_resp;
  logic [TW-1:0]  r_resptag;
  logic [7:0]     r_bad_cnt, w_bad_cnt_nxt;
  logic           w_latch, w_wr_en;
  logic           w_reqack_nxt, w_respcyc_nxt;
  logic [DW-1:0]  w_resp_nxt;
  logic [TW-1:0]  w_resptag_nxt;
  logic [AW-1:0]  w_base, w_word;
  logic [DW-1:0]  r_mem [MEM_WORDS];

  // Line-aligned word index; the adder wraps at the top of the array.
  assign w_base = {r_line[AW+2:LW], BW'(0)};
  assign w_word = w_base + AW'(r_beat);

  // Next state plus the values the output registers take in that state.
  always_comb begin
    w_state_nxt   = r_state;
    w_beat_nxt    = r_beat;
    w_wait_nxt    = r_wait;
    w_bad_cnt_nxt = r_bad_cnt;
    w_latch       = 1'b0;
    w_wr_en       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.bus_reqcyc) begin
          w_latch     = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        w_beat_nxt = '0;
        if (r_tag == TAG_WRITE) begin
          w_state_nxt = S_WDATA;
          w_wait_nxt  = WW'(WDATA_DELAY - 1);
        end else if (r_tag == TAG_READ) begin
          w_state_nxt = S_RWAIT;
          w_wait_nxt  = WW'(READ_LATENCY - 1);
        end else begin
          w_state_nxt = S_IDLE;
          if (r_bad_cnt != 8'hFF) w_bad_cnt_nxt = r_bad_cnt + 8'd1;
        end
      end
      S_WDATA: begin
        if (r_wait != '0) begin
          w_wait_nxt = r_wait - WW'(1);
        end else begin
          w_wr_en    = 1'b1;
          w_beat_nxt = r_beat + BW'(1);
          if (r_beat == BW'(BEATS - 1)) w_state_nxt = S_WRESP;
        end
      end
      S_WRESP: begin
        if (bus.bus_respack) w_state_nxt = S_IDLE;
      end
      S_RWAIT: begin
        if (r_wait != '0) w_wait_nxt = r_wait - WW'(1);
        else              w_state_nxt = S_RBEAT;
      end
      S_RBEAT: begin
        if (bus.bus_respack) begin
          if (r_beat == BW'(BEATS - 1)) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_RGAP;
            w_beat_nxt  = r_beat + BW'(1);
          end
        end
      end
      S_RGAP:  w_state_nxt = S_RBEAT;
      default: w_state_nxt = S_IDLE;
    endcase

    w_reqack_nxt  = (w_state_nxt == S_ACK);
    w_respcyc_nxt = (w_state_nxt == S_WRESP) || (w_state_nxt == S_RBEAT);
    w_resp_nxt    = '0;
    w_resptag_nxt = '0;
    if (w_state_nxt == S_WRESP) begin
      w_resp_nxt    = {r_line, LW'(0)};
      w_resptag_nxt = TAG_WRITE;
    end else if (w_state_nxt == S_RBEAT) begin
      // Beat data is captured on entry and held until acknowledged.
      w_resp_nxt    = (r_state == S_RBEAT) ? r_resp : r_mem[w_word];
      w_resptag_nxt = TAG_READ;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_line    <= '0;
      r_tag     <= '0;
      r_beat    <= '0;
      r_wait    <= '0;
      r_reqack  <= 1'b0;
      r_respcyc <= 1'b0;
      r_resp    <= '0;
      r_resptag <= '0;
      r_busy    <= 1'b0;
      r_bad_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      if (w_latch) begin
        r_line <= bus.bus_req[DW-1:LW];
        r_tag  <= bus.bus_reqtag;
      end
      r_beat    <= w_beat_nxt;
      r_wait    <= w_wait_nxt;
      r_reqack  <= w_reqack_nxt;
      r_respcyc <= w_respcyc_nxt;
      r_resp    <= w_resp_nxt;
      r_resptag <= w_resptag_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_bad_cnt <= w_bad_cnt_nxt;
    end
  end

  // Backing array survives reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_word] <= bus.bus_req;
  end

  assign bus.bus_reqack  = r_reqack;
  assign bus.bus_respcyc = r_respcyc;
  assign bus.bus_resp    = r_resp;
  assign bus.bus_resptag = r_resptag;
  assign busy            = r_busy;
  assign bad_tag_cnt     = r_bad_cnt;
endmodule
